wb_line_arbiter: RTL
====================

Name: wb_line_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter for 128-bit line transactions.
- Sits directly upstream of the physical memory slave. Master 0 is the instruction-side line fetcher; master 1 is the data-side line fill/writeback.
- Grants the single slave port to one master at a time. Holds the grant until the slave ACKs. Uses round-robin priority.

Parameters:
- ADR_W, 16, byte-address width; line index is ADR[15:4].
- DAT_W, 128, line width in bits.
- TIMEOUT_CYCLES, 1023, watchdog limit in clk cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  Wishbone CLK; shared by both masters and the slave.
- rst_n  in  1  asynchronous active-low reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 bus cycle / strobe / write enable.
- m0_adr  in  ADR_W  master 0 address.
- m0_dat_m  in  DAT_W  master 0 write data.
- m0_sel  in  DAT_W/8  master 0 byte select.
- m0_dat_s  out  DAT_W  read data to master 0.
- m0_ack, m0_rty, m0_err  out  1 each  responses to master 0.
- m1_*  same set as m0_*, for master 1.
- s_cyc, s_stb, s_we  out  1 each  to slave.
- s_adr  out  ADR_W  to slave.
- s_dat_m  out  DAT_W  to slave.
- s_sel  out  DAT_W/8  to slave.
- s_dat_s  in  DAT_W  read data from slave.
- s_ack, s_rty  in  1 each  responses from slave.

Behaviour:
- Reset: clk is the single clock domain. rst_n is asynchronous and active-low.
  - While rst_n=0: state=IDLE, last_grant=1 (so master 0 wins the first tie).
  - All s_* outputs are 0. m*_ack=0, m*_err=0, m*_dat_s=0.
  - m*_rty follows its master's cyc&stb.
- States:
  - IDLE
    - Neither request (mX_cyc&mX_stb): stay in IDLE.
    - One request: go to GRANTX.
    - Both request: grant the master not equal to last_grant.
  - GRANT0 / GRANT1
    - Slave-side outputs are driven combinationally from the granted master's inputs.
    - s_ack=1: go to IDLE next edge, and last_grant becomes the granted index.
    - Granted master drops cyc (abort): go to IDLE; last_grant is updated.
- Latency:
  - A request seen in IDLE at edge N appears on s_cyc/s_stb in the cycle after edge N.
  - Exactly one IDLE cycle separates back-to-back grants.
- Granted master:
  - mX_ack=s_ack, mX_rty=s_rty, mX_dat_s=s_dat_s.
- Non-granted master:
  - ack=0, dat_s=0.
  - rty=cyc&stb: the master is stalled and must hold adr/we/dat stable.
- In IDLE, every requesting master sees rty=1 and ack=0.
- Slave requirement: s_adr must not change during a grant. The arbiter passes the master's address through. Masters hold adr stable until ack, since the slave drops the response if adr[15:4] changes.
- s_ack while IDLE (spurious): ignored, not forwarded.
- Simultaneous new request and s_ack in the same cycle: the request is not granted until the following IDLE cycle.
- Reset asserted mid-grant:
  - s_cyc/s_stb drop immediately (asynchronously).
  - No ack is delivered for that transfer.
  - After release, arbitration restarts from IDLE with master 0 preferred.
- m*_err is 0 at all times unless ARB_TIMEOUT_EN is defined.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter clears on entry to GRANTx and increments every granted cycle without s_ack.
  - When it reaches TIMEOUT_CYCLES: pulse mX_err=1 for one cycle to the granted master, drop s_cyc/s_stb that cycle, go to IDLE, and update last_grant.
  - Counter resets to 0 on rst_n=0.
- Undefined: no counter is built, m*_err is tied 0, and a grant is held indefinitely until ack or abort.

Test Plan:
- Reset → outputs: hold rst_n=0 with m0 requesting → s_cyc=0, m0_ack=0, m0_rty=1. Release → s_cyc=1 with s_adr=m0_adr (0x0120) one cycle later.
- Single read: m1 read adr 0x0040, slave acks after 10 cycles with 0xDEADBEEF_... → m1_ack=1 for 1 cycle with m1_dat_s equal to that data. Next cycle the arbiter is IDLE.
- Contention round-robin: m0 and m1 request continuously → grants alternate m0, m1, m0, m1 with one IDLE cycle between. The stalled master sees rty=1 throughout.
- Write passthrough: m0 writes adr 0x0FF0 data 0x0123...CDEF while m1 requests → s_we=1 and s_dat_m matches until s_ack. m1 is granted only after that.
- Abort/reset mid-grant: m1 granted, then m1_cyc drops → IDLE next edge and no ack. Repeat with rst_n pulsed low mid-grant → s_cyc falls with no clock edge.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and the slave never acking → m0_err pulses at granted cycle 8, s_cyc=0, and a pending m1 is granted next.

Source files
------------

// File: rtl/wb_line_arbiter.sv
// -----------------------------------------------------------------------------
// wb_line_arbiter
//   Two-master to one-slave Wishbone arbiter for 128-bit line transactions.
//   Master 0 is the instruction-side line fetcher and master 1 is the
//   data-side fill/writeback. The slave port goes to one master at a time and
//   stays with that master until the slave acks or the master drops cyc.
//   Priority is round-robin: on a tie, the master that was not served last
//   wins. After reset, master 0 wins the first tie.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When ARB_TIMEOUT_EN is defined, a 16-bit watchdog aborts any grant that
//     has not been acked within TIMEOUT_CYCLES granted cycles. The granted
//     master receives a one-cycle err pulse.
//     When the macro is undefined, no counter is built, m*_err is 0, and a
//     grant is held until the slave acks or the master aborts.
//
// Ports
//   clk, rst_n                 Wishbone clock; asynchronous active-low reset
//   m0_* / m1_* (inputs)       cyc, stb, we, adr[ADR_W], dat_m[DAT_W],
//                              sel[DAT_W/8] from each master
//   m0_* / m1_* (outputs)      dat_s[DAT_W], ack, rty, err to each master
//   s_* (outputs)              cyc, stb, we, adr, dat_m, sel to the slave
//   s_dat_s, s_ack, s_rty      read data and responses from the slave
// -----------------------------------------------------------------------------
module wb_line_arbiter #(
  parameter int ADR_W          = 16,
  parameter int DAT_W          = 128,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [ADR_W-1:0]   m0_adr,
  input  logic [DAT_W-1:0]   m0_dat_m,
  input  logic [DAT_W/8-1:0] m0_sel,
  output logic [DAT_W-1:0]   m0_dat_s,
  output logic               m0_ack,
  output logic               m0_rty,
  output logic               m0_err,
  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [ADR_W-1:0]   m1_adr,
  input  logic [DAT_W-1:0]   m1_dat_m,
  input  logic [DAT_W/8-1:0] m1_sel,
  output logic [DAT_W-1:0]   m1_dat_s,
  output logic               m1_ack,
  output logic               m1_rty,
  output logic               m1_err,
  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [ADR_W-1:0]   s_adr,
  output logic [DAT_W-1:0]   s_dat_m,
  output logic [DAT_W/8-1:0] s_sel,
  input  logic [DAT_W-1:0]   s_dat_s,
  input  logic               s_ack,
  input  logic               s_rty
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_last_grant;
  logic       w_last_grant_nxt;
  logic       w_req0;
  logic       w_req1;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_timeout;

  assign w_req0 = m0_cyc & m0_stb;
  assign w_req1 = m1_cyc & m1_stb;
  assign w_gnt0 = (r_state == ST_GRANT0);
  assign w_gnt1 = (r_state == ST_GRANT1);

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wdog;

  // The watchdog is 0 in the first granted cycle, so it holds k-1 in granted
  // cycle k. The increment at the end of granted cycle TIMEOUT_CYCLES would
  // reach the limit, so the abort fires in that cycle. An ack in the same
  // cycle takes precedence over the timeout.
  assign w_timeout = (w_gnt0 | w_gnt1) & ~s_ack & (r_wdog == WDOG_LAST);

  // Watchdog: cleared while idle (and so on entry to a grant); counts granted cycles without ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= 16'd0;
    end else if (r_state == ST_IDLE) begin
      r_wdog <= 16'd0;
    end else if (!s_ack) begin
      r_wdog <= r_wdog + 16'd1;
    end else begin
      r_wdog <= r_wdog;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and round-robin pointer logic
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          // Tie: serve the master that was not served last
          if (r_last_grant) begin
            w_state_nxt = ST_GRANT0;
          end else begin
            w_state_nxt = ST_GRANT1;
          end
        end else if (w_req0) begin
          w_state_nxt = ST_GRANT0;
        end else if (w_req1) begin
          w_state_nxt = ST_GRANT1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT0: begin
        if (s_ack || !m0_cyc || w_timeout) begin
          w_state_nxt      = ST_IDLE;
          w_last_grant_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_GRANT0;
        end
      end
      ST_GRANT1: begin
        if (s_ack || !m1_cyc || w_timeout) begin
          w_state_nxt      = ST_IDLE;
          w_last_grant_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_GRANT1;
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_last_grant_nxt = 1'b1;
      end
    endcase
  end

  // State and last-grant registers; reset leaves master 0 preferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Slave port mux. Because it is decoded from the async-reset state, reset
  // drops s_cyc/s_stb at once without waiting for a clock edge.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_m = '0;
    s_sel   = '0;
    if (w_gnt0) begin
      s_cyc   = m0_cyc & ~w_timeout;
      s_stb   = m0_stb & ~w_timeout;
      s_we    = m0_we;
      s_adr   = m0_adr;
      s_dat_m = m0_dat_m;
      s_sel   = m0_sel;
    end else if (w_gnt1) begin
      s_cyc   = m1_cyc & ~w_timeout;
      s_stb   = m1_stb & ~w_timeout;
      s_we    = m1_we;
      s_adr   = m1_adr;
      s_dat_m = m1_dat_m;
      s_sel   = m1_sel;
    end else begin
      s_cyc = 1'b0;
    end
  end

  // Master responses: the granted master sees the slave. A stalled or idle
  // requester sees rty, which tells it to hold its request stable.
  always_comb begin
    m0_ack   = w_gnt0 & s_ack;
    m0_rty   = w_gnt0 ? s_rty : w_req0;
    m0_err   = w_gnt0 & w_timeout;
    m0_dat_s = w_gnt0 ? s_dat_s : '0;
    m1_ack   = w_gnt1 & s_ack;
    m1_rty   = w_gnt1 ? s_rty : w_req1;
    m1_err   = w_gnt1 & w_timeout;
    m1_dat_s = w_gnt1 ? s_dat_s : '0;
  end

endmodule
